// File: rtl/traffic_pkg.sv
// Shared types and default timing constants for the intersection front-end.
package traffic_pkg;

  typedef enum logic [1:0] {LOW, WAIT_HIGH, HIGH, WAIT_LOW} deb_state_t;

  localparam int unsigned TICK_DIV_SIM    = 4;
  localparam int unsigned TICK_DIV_BOARD  = 50_000_000;
  localparam int unsigned SHORT_TICKS_DEF = 3;
  localparam int unsigned LONG_TICKS_DEF  = 8;
  localparam int unsigned DEB_CYCLES_DEF  = 4;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sn_debounce.sv
// Two-flop synchroniser followed by a debounce FSM; clean changes only after
// DEB_CYCLES consecutive identical synchronised samples.
module sn_debounce
  import traffic_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic clean
);

  localparam int unsigned CntW = width_of(DEB_CYCLES);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEB_CYCLES - 1);

  logic            sync1_q, sync2_q;
  deb_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= LOW;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      LOW: begin
        if (sync2_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = CntOne;
        end
      end
      WAIT_HIGH: begin
        if (!sync2_q)               state_d = LOW;
        else if (cnt_q == CntLast)  state_d = HIGH;
        else                        cnt_d   = cnt_q + CntOne;
      end
      HIGH: begin
        if (!sync2_q) begin
          state_d = WAIT_LOW;
          cnt_d   = CntOne;
        end
      end
      WAIT_LOW: begin
        if (sync2_q)                state_d = HIGH;
        else if (cnt_q == CntLast)  state_d = LOW;
        else                        cnt_d   = cnt_q + CntOne;
      end
      default: state_d = LOW;
    endcase
  end

  // Decoded from registered state only, so no combinational glitches.
  assign clean = (state_q == HIGH) || (state_q == WAIT_LOW);

endmodule

// File: rtl/intersection_timing.sv
// Restartable interval timer (T/L) plus debounced car sensor (S) feeding the
// light controller.
module intersection_timing
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_DIV    = TICK_DIV_SIM,
  parameter int unsigned SHORT_TICKS = SHORT_TICKS_DEF,
  parameter int unsigned LONG_TICKS  = LONG_TICKS_DEF,
  parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic SN,
  input  logic restart,
  output logic T,
  output logic L,
  output logic S
);

  localparam int unsigned PreW = width_of(TICK_DIV);
  localparam int unsigned CntW = $clog2(LONG_TICKS + 1);
  localparam logic [PreW-1:0] PreLast = PreW'(TICK_DIV - 1);
  localparam logic [PreW-1:0] PreOne  = PreW'(1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] ShortC  = CntW'(SHORT_TICKS);
  localparam logic [CntW-1:0] LongC   = CntW'(LONG_TICKS);

  logic [PreW-1:0] presc_q, presc_d;
  logic [CntW-1:0] count_q, count_d;
  logic            tick;

  assign tick = (presc_q == PreLast);

  // restart beats a coincident tick so the new interval starts from zero.
  always_comb begin
    presc_d = presc_q + PreOne;
    count_d = count_q;
    if (restart) begin
      presc_d = '0;
      count_d = '0;
    end else if (tick) begin
      presc_d = '0;
      if (count_q < LongC) count_d = count_q + CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      count_q <= '0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
    end
  end

  assign T = (count_q >= ShortC);
  assign L = (count_q >= LongC);

  sn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_sn_debounce (
    .clk  (clk),
    .reset(reset),
    .raw  (SN),
    .clean(S)
  );

endmodule

// File: tb/tb_intersection_timing.sv
// Directed scenarios plus randomized traffic, every cycle compared against a
// time-since-restart / run-length reference model.
module tb_intersection_timing;

  localparam int TickDiv    = 4;
  localparam int ShortTicks = 3;
  localparam int LongTicks  = 8;
  localparam int DebCycles  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic SN = 1'b0;
  logic restart = 1'b0;
  logic T, L, S;

  intersection_timing dut (
    .clk    (clk),
    .reset  (reset),
    .SN     (SN),
    .restart(restart),
    .T      (T),
    .L      (L),
    .S      (S)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: edges since last restart/reset, sensor history and
  // run length of samples disagreeing with the current debounced level.
  int elapsed = 0;
  bit m_s = 1'b0;
  int run = 0;
  bit sn_d1 = 1'b0;
  bit sn_d2 = 1'b0;

  task automatic check_eq(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at t=%0t: got %b expected %b", tag, $time, got, exp);
  endtask

  task automatic step(input bit rst, input bit rs, input bit sn);
    int cnt;
    @(negedge clk);
    reset   = rst;
    restart = rs;
    SN      = sn;
    @(posedge clk);
    if (rst) begin
      elapsed = 0;
      m_s     = 1'b0;
      run     = 0;
      sn_d1   = 1'b0;
      sn_d2   = 1'b0;
    end else begin
      // The debouncer sees SN as it was two edges ago.
      if (sn_d2 != m_s) begin
        run++;
        if (run == DebCycles) begin
          m_s = ~m_s;
          run = 0;
        end
      end else begin
        run = 0;
      end
      sn_d2 = sn_d1;
      sn_d1 = sn;
      if (rs) elapsed = 0;
      else if (elapsed < 100000) elapsed++;
    end
    #1;
    cnt = elapsed / TickDiv;
    if (cnt > LongTicks) cnt = LongTicks;
    check_eq("T", T, cnt >= ShortTicks);
    check_eq("L", L, cnt >= LongTicks);
    check_eq("S", S, m_s);
  endtask

  initial begin
    int sn_hold;
    bit sn_val;

    // Reset held two cycles with the sensor already high.
    step(1, 0, 1);
    step(1, 0, 1);
    for (int i = 0; i < 20; i++) step(0, 0, 1);

    // Single restart, run well past saturation.
    step(1, 0, 0);
    for (int i = 0; i <= 110; i++) step(0, i == 10, 0);

    // Restart mid-interval after T is already high.
    step(1, 0, 0);
    for (int i = 0; i <= 70; i++) step(0, (i == 0) || (i == 20), 0);

    // Second restart lands on a tick.
    step(1, 0, 0);
    for (int i = 0; i <= 30; i++) step(0, (i == 0) || (i == 4), 0);

    // Short pulse rejection, clean edges and a brief low glitch.
    step(1, 0, 0);
    for (int i = 0; i <= 140; i++)
      step(0, 0, (i < 3) || (i >= 50 && i < 80) || (i >= 100 && !(i == 120 || i == 121)));

    // Reset in the middle of an interval.
    step(1, 0, 0);
    for (int i = 0; i <= 50; i++) step(i == 20, i == 0, 0);

    // Randomized traffic with runs of varying length and sparse restarts/resets.
    step(1, 0, 0);
    sn_hold = 0;
    sn_val  = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (sn_hold == 0) begin
        sn_val  = ~sn_val;
        sn_hold = $urandom_range(1, 9);
      end
      sn_hold--;
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 39) == 0), sn_val);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
